// File: rtl/ctrl_ajuste_campos.sv
// Edit sequencer: IDLE/EDIT mode, field selection and one-cycle up/down pulses.
// Optional hold-to-repeat is built only when CTRL_AJUSTE_AUTOREP_EN is defined.
`timescale 1ns/1ps
module ctrl_ajuste_campos #(
  parameter int HOLD_CYC    = 50_000_000,
  parameter int REP_CYC     = 10_000_000,
  parameter int TIMEOUT_CYC = 1_000_000_000,
  parameter int CNT_W       = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_edit,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [1:0] grupo,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       edit_active
);

  typedef enum logic {ST_IDLE = 1'b0, ST_EDIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam longint LP_CNT_MAX = (longint'(1) << CNT_W) - 1;

  generate
    if (longint'(HOLD_CYC) > LP_CNT_MAX || longint'(REP_CYC) > LP_CNT_MAX ||
        longint'(TIMEOUT_CYC) > LP_CNT_MAX || HOLD_CYC < 2 || REP_CYC < 1 ||
        TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("ctrl_ajuste_campos: timer parameters out of range for CNT_W");
    end
  endgenerate

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_idle_cnt, w_idle_nxt;
  logic [3:0]       r_btn_q;
  logic [3:0]       r_en_count;
  logic             r_up, r_dn;
  logic [3:0]       w_btn, w_rise;
  logic             w_any, w_stay_edit, w_pulse_ok;
  logic [1:0]       w_rep;

  // Bit order everywhere: {edit, right, up, down}.
  assign w_btn  = {btn_edit, btn_right, btn_up, btn_down};
  assign w_rise = w_btn & ~r_btn_q;
  assign w_any  = |w_btn;

  function automatic logic [3:0] f_code(input logic [1:0] g, input logic [1:0] idx);
    logic [3:0] base;
    case (g)
      2'd1:    base = 4'd4;
      2'd2:    base = 4'd8;
      default: base = 4'd1;
    endcase
    return base + {2'b00, idx};
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_idle_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        w_idx_nxt = '0;
        if (w_rise[3]) w_state_nxt = ST_EDIT;
      end
      ST_EDIT: begin
        if (w_rise[3]) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else if (!w_any) begin
          if (r_idle_cnt == LP_TO_LAST) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idle_nxt = r_idle_cnt + 1'b1;
          end
        end else if (w_rise[2]) begin
          w_idx_nxt = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        end
      end
    endcase
  end

  // Pulses only when EDIT persists, so en_count is never 0 while one is high.
  assign w_stay_edit = (r_state == ST_EDIT) && (w_state_nxt == ST_EDIT);
  assign w_pulse_ok  = w_stay_edit && !w_rise[2] && !(btn_up && btn_down);

`ifdef CTRL_AJUSTE_AUTOREP_EN
  localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LP_REP_LAST  = CNT_W'(REP_CYC - 1);

  logic [1:0]            r_grupo_q;
  logic [1:0][CNT_W-1:0] r_tmr;
  logic [1:0]            r_rep_ph, r_blk, w_run, w_hit;
  logic                  w_gchg;

  assign w_gchg   = (grupo != r_grupo_q);
  assign w_run[1] = w_stay_edit && btn_up && !btn_down && !w_rise[2];
  assign w_run[0] = w_stay_edit && btn_down && !btn_up && !w_rise[2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_hit[i] = (r_tmr[i] == (r_rep_ph[i] ? LP_REP_LAST : LP_HOLD_LAST));
      w_rep[i] = w_run[i] && w_hit[i] && !r_blk[i] && !w_gchg;
    end
  end

  // A hold that started outside EDIT or saw a group change stays blocked until release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grupo_q <= '0;
      r_tmr     <= '0;
      r_rep_ph  <= '0;
      r_blk     <= '0;
    end else begin
      r_grupo_q <= grupo;
      for (int i = 0; i < 2; i++) begin
        if (!w_run[i]) begin
          r_tmr[i]    <= '0;
          r_rep_ph[i] <= 1'b0;
        end else if (w_hit[i]) begin
          r_tmr[i]    <= '0;
          r_rep_ph[i] <= 1'b1;
        end else begin
          r_tmr[i] <= r_tmr[i] + 1'b1;
        end
        if (!w_btn[i]) r_blk[i] <= 1'b0;
        else if (r_state != ST_EDIT || w_gchg || w_rise[3]) r_blk[i] <= 1'b1;
      end
    end
  end
`else
  assign w_rep = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_idle_cnt <= '0;
      r_btn_q    <= '0;
      r_en_count <= '0;
      r_up       <= 1'b0;
      r_dn       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_btn_q    <= w_btn;
      r_en_count <= (w_state_nxt == ST_EDIT) ? f_code(grupo, w_idx_nxt) : 4'd0;
      r_up       <= w_pulse_ok && (w_rise[1] || w_rep[1]);
      r_dn       <= w_pulse_ok && (w_rise[0] || w_rep[0]);
    end
  end

  assign en_count    = r_en_count;
  assign enUP        = r_up;
  assign enDOWN      = r_dn;
  assign edit_active = (r_state == ST_EDIT);

endmodule

// File: tb/tb_ctrl_ajuste_campos.sv
// Bench for ctrl_ajuste_campos: directed scenarios plus random button traffic,
// checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_ctrl_ajuste_campos;
  localparam int H = 8;
  localparam int R = 4;
  localparam int T = 40;
`ifdef CTRL_AJUSTE_AUTOREP_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, btn_edit, btn_right, btn_up, btn_down;
  logic [1:0] grupo;
  logic [3:0] en_count;
  logic       enUP, enDOWN, edit_active;

  ctrl_ajuste_campos #(.HOLD_CYC(H), .REP_CYC(R), .TIMEOUT_CYC(T), .CNT_W(30)) dut (
    .clk(clk), .reset(reset), .btn_edit(btn_edit), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down), .grupo(grupo), .en_count(en_count),
    .enUP(enUP), .enDOWN(enDOWN), .edit_active(edit_active)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_up = 0;
  int n_dn = 0;
  bit chk_en = 1'b0;
  int base_tbl [4] = '{1, 4, 8, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Hold pulses fall at ages H-1, H-1+R, H-1+2R, ... of an uninterrupted hold.
  function automatic bit rep_due(input int age);
    return (age == H - 1) || (age > H - 1 && ((age - (H - 1)) % R) == 0);
  endfunction

  bit       m_edit;
  int       m_idx, m_idle;
  int       m_age [2];
  bit       m_blk [2];
  bit [3:0] m_prev;
  bit [1:0] m_pg;
  int       exp_en;
  bit       exp_up, exp_dn, exp_act;

  initial begin : model
    bit [3:0] b, rise;
    bit gchg, stay, nxt_edit, ok, own, other, rep;
    int nxt_idx;
    bit pl [2];
    forever begin
      @(posedge clk);
      b = {btn_edit, btn_right, btn_up, btn_down};
      if (reset) begin
        m_edit = 0; m_idx = 0; m_idle = 0; m_prev = '0; m_pg = '0;
        for (int c = 0; c < 2; c++) begin m_age[c] = 0; m_blk[c] = 0; end
        exp_en = 0; exp_up = 0; exp_dn = 0; exp_act = 0;
      end else begin
        rise = b & ~m_prev;
        gchg = (grupo != m_pg);
        nxt_edit = m_edit;
        nxt_idx = m_idx;
        if (!m_edit) begin
          if (rise[3]) nxt_edit = 1;
          nxt_idx = 0;
        end else if (rise[3]) nxt_edit = 0;
        else if (b == 0 && m_idle == T - 1) nxt_edit = 0;
        else if (rise[2]) nxt_idx = (m_idx + 1) % 3;
        stay = m_edit && nxt_edit;
        if (!m_edit || b != 0 || !nxt_edit) m_idle = 0;
        else m_idle++;
        ok = stay && !rise[2] && !(b[1] && b[0]);
        for (int c = 0; c < 2; c++) begin
          own = (c == 0) ? b[1] : b[0];
          other = (c == 0) ? b[0] : b[1];
          rep = AUTOREP && stay && own && !other && !rise[2] && !m_blk[c] && !gchg
                && rep_due(m_age[c]);
          pl[c] = ok && (((c == 0) ? rise[1] : rise[0]) || rep);
          if (stay && own && !other && !rise[2]) m_age[c]++;
          else m_age[c] = 0;
          if (!own) m_blk[c] = 0;
          else if (!m_edit || gchg || rise[3]) m_blk[c] = 1;
        end
        if (!nxt_edit) nxt_idx = 0;
        m_edit = nxt_edit;
        m_idx = nxt_idx;
        exp_en = m_edit ? base_tbl[grupo] + m_idx : 0;
        exp_act = m_edit;
        exp_up = pl[0];
        exp_dn = pl[1];
        m_prev = b;
        m_pg = grupo;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      if (enUP === 1'b1) n_up++;
      if (enDOWN === 1'b1) n_dn++;
      if (chk_en) begin
        check("en_count", 32'(en_count), 32'(exp_en));
        check("edit_active", 32'(edit_active), 32'(exp_act));
        check("enUP", 32'(enUP), 32'(exp_up));
        check("enDOWN", 32'(enDOWN), 32'(exp_dn));
        check("pulse_excl", 32'(enUP & enDOWN), 0);
        check("pulse_no_field", 32'((enUP | enDOWN) && en_count == 4'd0), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(input bit [3:0] v);
    {btn_edit, btn_right, btn_up, btn_down} = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int s1_exp [3] = '{9, 10, 8};
    int snap, cnt;
    reset = 1'b1;
    set_btns(4'b0000);
    grupo = 2'd0;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check("rst_en_count", 32'(en_count), 0);
    check("rst_edit_active", 32'(edit_active), 0);
    check("rst_pulses", 32'(enUP | enDOWN), 0);
    reset = 1'b0;
    tick(2);

    // S1: enter EDIT on the timer group and walk the fields
    grupo = 2'd2;
    set_btns(4'b1000); tick();
    check("s1_edit_active", 32'(edit_active), 1);
    check("s1_code_ss", 32'(en_count), 8);
    set_btns(4'b0000); tick();
    for (int i = 0; i < 3; i++) begin
      set_btns(4'b0100); tick();
      check("s1_right_code", 32'(en_count), 32'(s1_exp[i]));
      set_btns(4'b0000); tick();
    end

    // S2: single up and down presses on HH_T
    for (int i = 0; i < 2; i++) begin
      set_btns(4'b0100); tick(); set_btns(4'b0000); tick();
    end
    check("s2_code_hh", 32'(en_count), 10);
    snap = n_up;
    set_btns(4'b0010); tick();
    check("s2_up_latency", 32'(enUP), 1);
    tick(2); set_btns(4'b0000); tick(4);
    check("s2_up_count", 32'(n_up - snap), 1);
    snap = n_dn;
    set_btns(4'b0001); tick();
    check("s2_dn_latency", 32'(enDOWN), 1);
    tick(2); set_btns(4'b0000); tick(4);
    check("s2_dn_count", 32'(n_dn - snap), 1);

    // S3: 30-cycle hold
    snap = n_up;
    set_btns(4'b0010); tick(30); set_btns(4'b0000); tick(3);
    check("s3_hold_count", 32'(n_up - snap), AUTOREP ? 7 : 1);

    // S4: up+down together, then edit and up rising together
    snap = n_up + n_dn;
    set_btns(4'b0011); tick(20); set_btns(4'b0000); tick(2);
    check("s4_both_count", 32'(n_up + n_dn - snap), 0);
    check("s4_still_edit", 32'(edit_active), 1);
    snap = n_up;
    set_btns(4'b1010); tick();
    check("s4_exit_edit", 32'(edit_active), 0);
    set_btns(4'b0000); tick(3);
    check("s4_no_up", 32'(n_up - snap), 0);

    // S5: idle timeout, then up in IDLE
    set_btns(4'b1000); tick(); set_btns(4'b0000);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (edit_active !== 1'b1) break;
      cnt++;
      tick();
    end
    check("s5_timeout_len", 32'(cnt), 40);
    check("s5_code_idle", 32'(en_count), 0);
    snap = n_up;
    set_btns(4'b0010); tick(3); set_btns(4'b0000); tick(2);
    check("s5_idle_up", 32'(n_up - snap), 0);

    // S6: reset during down repeat
    grupo = 2'd0;
    set_btns(4'b1000); tick(); set_btns(4'b0000);
    check("s6_code_ss", 32'(en_count), 1);
    set_btns(4'b0001); tick(14);
    reset = 1'b1; tick();
    check("s6_rst_edit", 32'(edit_active), 0);
    check("s6_rst_code", 32'(en_count), 0);
    check("s6_rst_dn", 32'(enDOWN), 0);
    snap = n_dn;
    reset = 1'b0; tick(15); set_btns(4'b0000); tick(2);
    check("s6_no_dn_after", 32'(n_dn - snap), 0);

    // Random traffic
    for (int s = 0; s < 220; s++) begin
      int k, len;
      bit [3:0] v;
      k = $urandom_range(0, 99);
      len = $urandom_range(1, 24);
      if (edit_active !== 1'b1 && $urandom_range(0, 1) == 1) k = 0;
      if ($urandom_range(0, 9) == 0) grupo = 2'($urandom_range(0, 3));
      if (k < 8) begin
        set_btns(4'b1000); tick(); set_btns(4'b0000); tick();
      end else if (k < 22) begin
        set_btns(4'b0100); tick(); set_btns(4'b0000); tick(1 + len % 3);
      end else if (k < 70) begin
        v = (k < 46) ? 4'b0010 : ((k < 64) ? 4'b0001 : 4'b0011);
        set_btns(v);
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 15) == 0) grupo = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 19) == 0) btn_right = 1'b1;
          tick();
          btn_right = 1'b0;
        end
        set_btns(4'b0000); tick();
      end else if (k < 75) begin
        reset = 1'b1; tick(); reset = 1'b0; tick();
      end else begin
        set_btns(4'b0000); tick(len * 2);
      end
    end

    set_btns(4'b0000);
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_ajuste_campos.md
Name: ctrl_ajuste_campos

Overview:
- Edit sequencer for the RTC/timer counter bank.
- Enters and exits edit mode and selects which 2-digit counter is being edited by driving the shared en_count field code.
- Converts debounced push-button levels into single-cycle enUP/enDOWN pulses, with hold-to-repeat.
- Sits between the button debouncers and all contador_* field counters; hours-of-timer is field code 10.

Parameters:
- HOLD_CYC, 50_000_000: cycles a button must stay held before auto-repeat starts.
- REP_CYC, 10_000_000: cycles between auto-repeat pulses.
- TIMEOUT_CYC, 1_000_000_000: idle cycles (no button activity) in EDIT before automatic exit.
- CNT_W, 30: width of the internal timers; must hold the largest of the three parameters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_edit  in  1  debounced level; a rising edge toggles edit mode
- btn_right  in  1  debounced level; a rising edge selects the next field
- btn_up  in  1  debounced level; increment
- btn_down  in  1  debounced level; decrement
- grupo  in  2  field group: 0 = clock, 1 = date, 2 = timer, 3 = reserved (treated as 0)
- en_count  out  4  field code to the counters; 0 = none selected
- enUP  out  1  one-cycle increment pulse
- enDOWN  out  1  one-cycle decrement pulse
- edit_active  out  1  high while in EDIT

Behaviour:
- Reset values: en_count = 0, enUP = 0, enDOWN = 0, edit_active = 0, state = IDLE, field index = 0, all timers = 0, edge registers = 0.
- Field code table, per group, for index 0/1/2:
  - clock: 1 / 2 / 3 (SS, MM, HH)
  - date: 4 / 5 / 6 (DD, MO, YY)
  - timer: 8 / 9 / 10 (SS_T, MM_T, HH_T)
- Edge detection: each button is registered once; rise = btn & ~btn_q.
- State IDLE:
  - en_count = 0; enUP and enDOWN held at 0.
  - A btn_edit rise moves to EDIT with index = 0.
- State EDIT:
  - en_count is a registered decode of (grupo, index); it updates the cycle after grupo or index changes.
  - A btn_right rise sets index = index + 1, wrapping 2 -> 0. The repeat timer clears and no pulse is issued that cycle.
  - A btn_edit rise returns to IDLE. It has priority over every other button in the same cycle.
  - Timeout: the timer counts cycles with all four buttons low. On reaching TIMEOUT_CYC-1 the block returns to IDLE. Any button high clears the timer.
- State machine is two-state: IDLE <-> EDIT. Index is retained only while in EDIT; entering EDIT always starts at index 0.
- Increment/decrement, EDIT only:
  - btn_up rise -> enUP = 1 for exactly one cycle, asserted in the cycle after the rise (1-cycle latency from the registered edge).
  - Hold: while btn_up stays high, the hold timer counts. At HOLD_CYC it emits a pulse and reloads for REP_CYC. A further pulse follows every REP_CYC cycles.
  - btn_down behaves identically on enDOWN.
  - btn_up and btn_down both high: no pulses, and both timers clear.
  - Releasing the button clears its timer.
- Invariants:
  - enUP and enDOWN are never high in the same cycle.
  - Neither pulse is ever issued while en_count = 0.
- grupo changing during EDIT: index is kept and en_count follows the new group next cycle. Any repeat in progress is cancelled until the button is released and pressed again.
- Reset asserted mid-hold or mid-edit: the block returns to IDLE the next clk edge and no pulse is emitted in the reset cycle.

Optional Feature:
- Macro: CTRL_AJUSTE_AUTOREP_EN.
- Defined: hold-to-repeat behaves as described above.
- Undefined: only the single pulse per rising edge is emitted. Hold and repeat timers are not built. HOLD_CYC and REP_CYC are ignored. Timeout is unaffected.

Test Plan:
All scenarios use HOLD_CYC = 8, REP_CYC = 4, TIMEOUT_CYC = 40.
1. Reset, then btn_edit pulse with grupo = 2 -> edit_active = 1 and en_count = 8. Three btn_right pulses -> en_count = 9, 10, 8.
2. In EDIT with grupo = 2, index = 2 (en_count = 10): single 3-cycle btn_up press -> exactly one enUP pulse, one cycle after the rise. btn_down press -> exactly one enDOWN pulse.
3. btn_up held 30 cycles, with CTRL_AJUSTE_AUTOREP_EN defined -> pulses at the rise+1, +8, +12, +16, +20, +24, +28 offsets, i.e. 7 enUP pulses. Without the macro -> 1 pulse.
4. btn_up and btn_down high together for 20 cycles -> zero pulses. btn_edit rise in the same cycle as a btn_up rise -> IDLE, no enUP.
5. Enter EDIT and leave all buttons low -> edit_active drops after 40 cycles and en_count = 0. btn_up in IDLE -> no pulse.
6. Reset asserted during the repeat phase of a held btn_down -> next cycle: IDLE, en_count = 0, no further enDOWN even though btn_down is still high.
